// File: rtl/ppu_writer.sv
// PPU bus write initiator: buffers (address, data) pairs in a FIFO and drains
// them during vertical blank, or at once while immediate mode is set.
//
// state | meaning
// IDLE  | no write in flight; waits for batch work or immediate work
// ISSUE | strobes high for one cycle with the head popped on entry
// GAP   | strobes low; WRITE_GAP idle bus cycles before the next decision
module ppu_writer #(
  parameter int DEPTH     = 16,
  parameter int WRITE_GAP = 1,
  parameter int VACTIVE   = 480
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [15:0]            push_addr_i,
  input  logic [31:0]            push_data_i,
  input  logic                   immediate_i,
  input  logic [9:0]             vcount_i,
  output logic                   chipselect_o,
  output logic                   write_o,
  output logic [15:0]            address_o,
  output logic [31:0]            writedata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   frame_done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [2:0] GAP_LOAD = (WRITE_GAP > 0) ? 3'(WRITE_GAP - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [15:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d, batch_q, batch_d;
  logic [2:0]    gap_q, gap_d;
  state_t        state_q, state_d;
  logic          prev_vblank_q, vblank, push_fire, issue, work;
  logic          cs_q, last_q, frame_done_q;
  logic [15:0]   address_q;
  logic [31:0]   writedata_q;

  assign push_ready_o = (level_q != FULL);
  assign push_fire    = push_valid_i && push_ready_o;
  assign vblank       = (vcount_i >= 10'(VACTIVE));
  // batch never exceeds level, so immediate work is simply "anything queued"
  assign work         = immediate_i ? (level_q != '0) : (batch_q != '0);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (work) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (WRITE_GAP > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else if (work) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q != 3'd0) begin
          gap_d = gap_q - 3'd1;
        end else if (work) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push_fire, issue})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    batch_d = batch_q;
    if (immediate_i) begin
      batch_d = '0;
    end else if (!prev_vblank_q && vblank) begin
      batch_d = level_q;
    end else if (issue) begin
      batch_d = batch_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      gap_q         <= 3'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      batch_q       <= '0;
      prev_vblank_q <= 1'b1;
      cs_q          <= 1'b0;
      last_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      address_q     <= '0;
      writedata_q   <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      level_q       <= level_d;
      batch_q       <= batch_d;
      prev_vblank_q <= vblank;
      cs_q          <= issue;
      last_q        <= issue && !immediate_i && (batch_q == ONE);
      frame_done_q  <= last_q;
      if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (issue) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        address_q   <= addr_mem[rd_ptr_q];
        writedata_q <= data_mem[rd_ptr_q];
      end
    end
  end

  assign chipselect_o = cs_q;
  assign write_o      = cs_q;
  assign address_o    = address_q;
  assign writedata_o  = writedata_q;
  assign level_o      = level_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ppu_writer.sv
// Bench for ppu_writer: directed scenarios with literal expectations plus a
// randomized run compared cycle by cycle against a queue-based reference.
`timescale 1ns/1ps
module tb_ppu_writer;
  localparam int DEPTH     = 16;
  localparam int WRITE_GAP = 1;
  localparam int VACTIVE   = 480;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_valid = 1'b0;
  logic [15:0]   push_addr = '0;
  logic [31:0]   push_data = '0;
  logic          immediate = 1'b0;
  logic [9:0]    vcount = 10'd100;
  logic          push_ready, chipselect, write, frame_done;
  logic [15:0]   address;
  logic [31:0]   writedata;
  logic [LW-1:0] level;

  always #10 clk = ~clk;

  ppu_writer #(.DEPTH(DEPTH), .WRITE_GAP(WRITE_GAP), .VACTIVE(VACTIVE)) dut (
    .clk_i(clk), .reset_i(reset), .push_valid_i(push_valid), .push_ready_o(push_ready),
    .push_addr_i(push_addr), .push_data_i(push_data), .immediate_i(immediate),
    .vcount_i(vcount), .chipselect_o(chipselect), .write_o(write), .address_o(address),
    .writedata_o(writedata), .level_o(level), .frame_done_o(frame_done)
  );

  int     vectors = 0;
  int     errors  = 0;
  longint cyc     = 0;
  longint t_a     = 0;
  bit     check_en = 1'b0;

  // Reference: queue of pending writes, batch count, and the earliest cycle
  // at which the next write may be decided (writes spaced WRITE_GAP+1 apart).
  logic [47:0] mq[$];
  int          m_batch = 0;
  bit          m_prev_vb = 1'b1;
  longint      m_next = 0;
  bit          m_cs = 1'b0, m_last = 1'b0, m_fd = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin : model
    bit vb, work, iss;
    int qn;
    logic [47:0] e;
    if (reset) begin
      mq.delete();
      m_batch = 0; m_prev_vb = 1'b1; m_next = 0;
      m_cs = 1'b0; m_last = 1'b0; m_fd = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      qn   = mq.size();
      vb   = (vcount >= VACTIVE);
      work = (immediate && qn > 0) || (m_batch > 0);
      iss  = work && (cyc >= m_next);
      m_fd = m_last;
      m_last = 1'b0;
      m_cs = iss;
      if (iss) begin
        e = mq.pop_front();
        m_addr = e[47:32];
        m_data = e[31:0];
        m_next = cyc + 1 + WRITE_GAP;
        m_last = !immediate && (m_batch == 1);
      end
      if (immediate) m_batch = 0;
      else if (!m_prev_vb && vb) m_batch = qn;
      else if (iss) m_batch = m_batch - 1;
      if (push_valid && qn != DEPTH) mq.push_back({push_addr, push_data});
      m_prev_vb = vb;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (chipselect !== m_cs || write !== m_cs || address !== m_addr || writedata !== m_data ||
          level !== LW'(mq.size()) || push_ready !== (mq.size() != DEPTH) || frame_done !== m_fd) begin
        errors++;
        $display("FAIL cycle_cmp @%0d: got cs=%b wr=%b a=%h d=%h lvl=%0d rdy=%b fd=%b; want cs=%b a=%h d=%h lvl=%0d rdy=%b fd=%b",
                 cyc, chipselect, write, address, writedata, level, push_ready, frame_done,
                 m_cs, m_addr, m_data, mq.size(), (mq.size() != DEPTH), m_fd);
      end
    end
  end

  longint      w_cyc[$];
  logic [15:0] w_addr[$];
  logic [31:0] w_data[$];
  longint      fd_cyc[$];

  always @(negedge clk) begin
    if (chipselect === 1'b1) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(address);
      w_data.push_back(writedata);
    end
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
  end

  task automatic clear_log();
    w_cyc.delete(); w_addr.delete(); w_data.delete(); fd_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    push_valid = 1'b1; push_addr = a; push_data = d;
    tick(1);
    push_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic enter_vblank();
    vcount = 10'd479;
    tick(2);
    vcount = 10'd480;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_en = 1'b1;
    chk("reset_level", level, 0);
    chk("reset_ready", push_ready, 1);
    chk("reset_cs", chipselect, 0);

    // immediate load, back-to-back pushes
    immediate = 1'b1; vcount = 10'd100;
    clear_log();
    push(16'h0100, 32'hDEADBEEF);
    t_a = cyc;
    push(16'h0201, 32'h00FF00FF);
    tick(10);
    chk("imm_writes", w_cyc.size(), 2);
    if (w_cyc.size() == 2) begin
      chk("imm_first_cycle", w_cyc[0] - t_a + 1, 2);
      chk("imm_second_cycle", w_cyc[1] - t_a + 1, 4);
      chk("imm_addr0", w_addr[0], 16'h0100);
      chk("imm_data0", w_data[0], 32'hDEADBEEF);
      chk("imm_addr1", w_addr[1], 16'h0201);
      chk("imm_data1", w_data[1], 32'h00FF00FF);
    end
    chk("imm_no_frame_done", fd_cyc.size(), 0);

    // vblank gating
    do_reset();
    immediate = 1'b0; vcount = 10'd100;
    clear_log();
    push(16'h0010, 32'h11111111);
    push(16'h0120, 32'h22222222);
    push(16'h0230, 32'h33333333);
    tick(10);
    chk("gate_no_writes", w_cyc.size(), 0);
    chk("gate_level", level, 3);
    enter_vblank();
    tick(20);
    chk("gate_writes", w_cyc.size(), 3);
    if (w_cyc.size() == 3) begin
      chk("gate_spacing01", w_cyc[1] - w_cyc[0], 2);
      chk("gate_spacing12", w_cyc[2] - w_cyc[1], 2);
      chk("gate_addr0", w_addr[0], 16'h0010);
      chk("gate_addr2", w_addr[2], 16'h0230);
      chk("gate_data1", w_data[1], 32'h22222222);
      chk("gate_fd_count", fd_cyc.size(), 1);
      if (fd_cyc.size() == 1) chk("gate_fd_cycle", fd_cyc[0] - w_cyc[2], 1);
    end
    chk("gate_level_after", level, 0);

    // snapshot boundary
    vcount = 10'd100;
    tick(3);
    clear_log();
    push(16'h0300, 32'h0000000A);
    push(16'h0301, 32'h0000000B);
    enter_vblank();
    tick(1);
    push(16'h0302, 32'h0000000C);
    tick(20);
    chk("snap_writes", w_cyc.size(), 2);
    chk("snap_level", level, 1);
    vcount = 10'd100;
    tick(3);
    enter_vblank();
    tick(10);
    chk("snap_writes_next", w_cyc.size(), 3);
    if (w_cyc.size() == 3) chk("snap_third_addr", w_addr[2], 16'h0302);
    chk("snap_level_next", level, 0);

    // full FIFO
    do_reset();
    immediate = 1'b0; vcount = 10'd100;
    clear_log();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("full_ready_low", push_ready, 0);
      push(16'h1000 + 16'(i), 32'hC0DE0000 + 32'(i));
    end
    tick(2);
    chk("full_level", level, 16);
    enter_vblank();
    tick(40);
    chk("full_writes", w_cyc.size(), 16);
    if (w_cyc.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("full_order_addr", w_addr[i], 16'h1000 + 16'(i));
        chk("full_order_data", w_data[i], 32'hC0DE0000 + 32'(i));
      end
    end
    chk("full_fd_count", fd_cyc.size(), 1);

    // reset mid-batch
    vcount = 10'd100;
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) push(16'h2000 + 16'(i), 32'h5000 + 32'(i));
    enter_vblank();
    for (int k = 0; k < 30 && w_cyc.size() < 2; k++) tick(1);
    chk("mid_two_writes", w_cyc.size(), 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", chipselect, 0);
    chk("mid_rst_wr", write, 0);
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_data", writedata, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ready", push_ready, 1);
    tick(2);
    reset = 1'b0;
    clear_log();
    tick(5);
    vcount = 10'd100;
    tick(3);
    enter_vblank();
    tick(20);
    chk("mid_no_writes_after", w_cyc.size(), 0);
    chk("mid_no_fd_after", fd_cyc.size(), 0);

    // reset released inside vblank
    vcount = 10'd500;
    do_reset();
    clear_log();
    push(16'h0333, 32'h12345678);
    push(16'h0334, 32'h9ABCDEF0);
    tick(10);
    chk("rvb_no_writes", w_cyc.size(), 0);
    chk("rvb_level", level, 2);
    vcount = 10'd100;
    tick(3);
    vcount = 10'd479;
    tick(1);
    vcount = 10'd480;
    tick(10);
    chk("rvb_writes", w_cyc.size(), 2);
    chk("rvb_fd", fd_cyc.size(), 1);

    // randomized frames against the reference
    do_reset();
    for (int ph = 0; ph < 60; ph++) begin
      int vis_len, vb_len, rate;
      immediate = ($urandom_range(0, 3) == 0);
      rate = $urandom_range(0, 3);
      vis_len = $urandom_range(2, 25);
      vb_len = $urandom_range(DEPTH * (WRITE_GAP + 1) + 6, 60);
      for (int c = 0; c < vis_len + vb_len; c++) begin
        if (c < vis_len) vcount = ($urandom_range(0, 7) == 0) ? 10'd479 : 10'($urandom_range(0, 478));
        else if (c == vis_len) vcount = 10'd480;
        else vcount = 10'($urandom_range(480, 1023));
        push_valid = ($urandom_range(0, 3) < rate);
        push_addr = 16'($urandom);
        push_data = $urandom;
        tick(1);
      end
    end
    push_valid = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
